// File: rtl/snn_mem_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and LEN width for the SNN memory load controller.
// SNN_MEM_CTRL_READBACK_EN adds the read-back states.
package snn_mem_ctrl_pkg;

    localparam int unsigned LEN_W = 8;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_CLR   = 8'h0F;

    typedef enum logic [2:0] {
        IDLE,
        HDR_AH,
        HDR_AL,
        HDR_LEN,
        WR_DATA
`ifdef SNN_MEM_CTRL_READBACK_EN
        ,
        RD_ISSUE,
        RD_WAIT
`endif
    } state_t;

endpackage

// File: rtl/snn_mem_load_ctrl.sv
// Byte-stream framed command decoder that writes (and optionally reads back) the SNN weight memory.
// Read-back path is built only when SNN_MEM_CTRL_READBACK_EN is defined.
module snn_mem_load_ctrl
    import snn_mem_ctrl_pkg::*;
#(
    parameter int unsigned M  = 320,
    parameter int unsigned N  = 8,
    parameter int unsigned AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic          busy,
    output logic          err,
    output logic          load_done
);

    // 16-bit header address plus up to 255 increments needs one extra bit.
    localparam int unsigned CAW = 17;

    if (N != 8) begin : g_bad_width
        $error("snn_mem_load_ctrl: N must be 8");
    end

    state_t           state;
    logic [7:0]       addr_hi;
    logic [CAW-1:0]   cur_addr;
    logic [LEN_W-1:0] cnt;
    logic             accept_c;
    logic             in_rng_c;
    logic             err_set_c;
    logic             err_clr_c;

    assign accept_c = in_valid & in_ready;
    assign in_rng_c = cur_addr < CAW'(M);
    assign busy     = (state != IDLE);

`ifdef SNN_MEM_CTRL_READBACK_EN
    logic is_rd;
`else
    logic unused_rd;
    assign unused_rd = ^{mem_rdata, out_ready};
    assign out_data  = '0;
    assign out_valid = 1'b0;
`endif

    // Error events; a set in the same cycle as a clear wins.
    always_comb begin
        err_set_c = 1'b0;
        err_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (in_data == OP_CLR) begin
                        err_clr_c = 1'b1;
                    end else if (in_data != OP_WRITE
`ifdef SNN_MEM_CTRL_READBACK_EN
                                 && in_data != OP_READ
`endif
                                ) begin
                        err_set_c = 1'b1;
                    end
                end
            end
            HDR_LEN, WR_DATA: begin
                if (accept_c && !in_rng_c) err_set_c = 1'b1;
            end
`ifdef SNN_MEM_CTRL_READBACK_EN
            RD_ISSUE: begin
                if (!in_rng_c) err_set_c = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_hi   <= '0;
            cur_addr  <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            err       <= 1'b0;
            load_done <= 1'b0;
`ifdef SNN_MEM_CTRL_READBACK_EN
            is_rd     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            in_ready  <= 1'b1;
            err       <= (err & ~err_clr_c) | err_set_c;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (in_data == OP_WRITE) begin
`ifdef SNN_MEM_CTRL_READBACK_EN
                            is_rd <= 1'b0;
`endif
                            state <= HDR_AH;
                        end
`ifdef SNN_MEM_CTRL_READBACK_EN
                        else if (in_data == OP_READ) begin
                            is_rd <= 1'b1;
                            state <= HDR_AH;
                        end
`endif
                    end
                end
                HDR_AH: begin
                    if (accept_c) begin
                        addr_hi <= in_data;
                        state   <= HDR_AL;
                    end
                end
                HDR_AL: begin
                    if (accept_c) begin
                        cur_addr <= CAW'({addr_hi, in_data});
                        state    <= HDR_LEN;
                    end
                end
                HDR_LEN: begin
                    if (accept_c) begin
                        cnt <= in_data;
`ifdef SNN_MEM_CTRL_READBACK_EN
                        if (is_rd) begin
                            mem_addr <= AW'(cur_addr);
                            in_ready <= 1'b0;
                            state    <= RD_ISSUE;
                        end else begin
                            state <= WR_DATA;
                        end
`else
                        state <= WR_DATA;
`endif
                    end
                end
                WR_DATA: begin
                    if (accept_c) begin
                        if (in_rng_c) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= AW'(cur_addr);
                            mem_wdata <= in_data;
                        end
                        cur_addr <= cur_addr + CAW'(1);
                        if (cnt == '0) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end
`ifdef SNN_MEM_CTRL_READBACK_EN
                RD_ISSUE: begin
                    out_data  <= in_rng_c ? mem_rdata : 8'h00;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cur_addr  <= cur_addr + CAW'(1);
                        mem_addr  <= AW'(cur_addr + CAW'(1));
                        if (cnt == '0) begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt   <= cnt - LEN_W'(1);
                            state <= RD_ISSUE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_mem_load_ctrl.sv
// Directed self-checking bench for snn_mem_load_ctrl with a behavioural 512-byte memory.
module tb_snn_mem_load_ctrl;

    localparam int unsigned M  = 320;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          err;
    logic          load_done;

    logic [7:0] mem [0:511];
    int n_chk  = 0;
    int n_pass = 0;
    int ld_count = 0;
    int cyc = 0;
    int log_addr[$];
    int log_data[$];
    int log_ld[$];
    int log_cyc[$];

    snn_mem_load_ctrl #(.M(M), .N(8), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .err(err), .load_done(load_done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and write/load_done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(int'(mem_wdata));
            log_ld.push_back(int'(load_done));
            log_cyc.push_back(cyc);
        end
        if (load_done) ld_count = ld_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_ld.delete();
        log_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

`ifdef SNN_MEM_CTRL_READBACK_EN
    task automatic read_byte(input logic [7:0] exp);
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_valid", 32'(out_valid), 32'd1);
        chk("rd_data", 32'(out_data), 32'(exp));
        chk("rd_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rd_hold_data", 32'(out_data), 32'(exp));
        chk("rd_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rd_valid_drop", 32'(out_valid), 32'd0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Write burst 01 00 05 02 AA BB CC
        clear_log();
        ld_count = 0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        settle();
        chk("wr_count", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("wr_addr0", 32'(log_addr[0]), 32'd5);
            chk("wr_addr1", 32'(log_addr[1]), 32'd6);
            chk("wr_addr2", 32'(log_addr[2]), 32'd7);
            chk("wr_data0", 32'(log_data[0]), 32'hAA);
            chk("wr_data1", 32'(log_data[1]), 32'hBB);
            chk("wr_data2", 32'(log_data[2]), 32'hCC);
            chk("wr_back2back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
            chk("wr_ld_first", 32'(log_ld[0]), 32'd0);
            chk("wr_ld_last", 32'(log_ld[2]), 32'd1);
        end
        chk("wr_ld_count", 32'(ld_count), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_busy", 32'(busy), 32'd0);

`ifdef SNN_MEM_CTRL_READBACK_EN
        // Read back with out_ready toggling
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h05); send_byte(8'h02);
        read_byte(8'hAA);
        read_byte(8'hBB);
        read_byte(8'hCC);
        settle();
        chk("rd_done_busy", 32'(busy), 32'd0);
        chk("rd_done_in_ready", 32'(in_ready), 32'd1);
        chk("rd_err", 32'(err), 32'd0);

        // Out-of-range read returns zero and flags err
        mem[320 & 511] = 8'h5A;
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h40); send_byte(8'h00);
        read_byte(8'h00);
        settle();
        chk("rd_oor_err", 32'(err), 32'd1);
        send_byte(8'h0F);
        chk("rd_oor_clr", 32'(err), 32'd0);
`else
        // Read opcode is illegal without read-back
        send_byte(8'h02);
        settle();
        chk("op02_err", 32'(err), 32'd1);
        chk("op02_busy", 32'(busy), 32'd0);
        send_byte(8'h0F);
        chk("op02_clr", 32'(err), 32'd0);
        chk("op02_out_valid", 32'(out_valid), 32'd0);
`endif

        // Out-of-range write
        clear_log();
        ld_count = 0;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h11);
        settle();
        chk("oor_no_we", 32'(log_addr.size()), 32'd0);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        send_byte(8'h0F);
        chk("oor_clr", 32'(err), 32'd0);

        // Burst crossing the top of memory
        clear_log();
        ld_count = 0;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h3F); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h66);
        settle();
        chk("bnd_count", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("bnd_addr", 32'(log_addr[0]), 32'd319);
            chk("bnd_data", 32'(log_data[0]), 32'h55);
        end
        chk("bnd_mem0", 32'(mem[0]), 32'h00);
        chk("bnd_ld", 32'(ld_count), 32'd1);
        chk("bnd_err", 32'(err), 32'd1);
        send_byte(8'h0F);
        chk("bnd_clr", 32'(err), 32'd0);

        // Illegal opcode, then a valid frame still executes
        send_byte(8'h07);
        settle();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        clear_log();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h99);
        settle();
        chk("ill_next_count", 32'(log_addr.size()), 32'd1);
        chk("ill_next_mem", 32'(mem[32]), 32'h99);
        chk("ill_err_sticky", 32'(err), 32'd1);

        // Reset mid-frame aborts it
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_ld", 32'(load_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h77);
        settle();
        chk("post_rst_count", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) chk("post_rst_addr", 32'(log_addr[0]), 32'd0);
        chk("post_rst_mem", 32'(mem[0]), 32'h77);
        chk("post_rst_mem10", 32'(mem[16]), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
